// File: rtl/uart_tx_engine_if.sv
// Byte-source side of the UART transmit engine: frame configuration,
// valid/ready byte handshake, serial line and status outputs.
interface uart_tx_if #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 16
);
  logic [DIV_W-1:0] clk_div;
  logic             check_en;
  logic [1:0]       check_type;
  logic [1:0]       data_bit;
  logic [1:0]       stop_bit;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             uart_tx;
  logic             tx_busy;
  logic [CNT_W-1:0] tx_byte_count;

  // Byte source / configuration owner.
  modport master (
    output clk_div, check_en, check_type, data_bit, stop_bit, tx_data, tx_valid,
    input  tx_ready, uart_tx, tx_busy, tx_byte_count
  );

  // Transmit engine.
  modport slave (
    input  clk_div, check_en, check_type, data_bit, stop_bit, tx_data, tx_valid,
    output tx_ready, uart_tx, tx_busy, tx_byte_count
  );
endinterface

// File: rtl/uart_tx_engine.sv
// UART transmit engine: start bit, 5..8 LSB-first data bits, optional
// parity, 1/1.5/2 stop bits. Frame format and baud divisor are captured
// when a byte is accepted, so configuration changes only affect later frames.
module uart_tx_engine #(
  parameter int DIV_W = 32,
  parameter int CNT_W = 16
) (
  input logic      clk,
  input logic      rst,
  uart_tx_if.slave tx_if
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

  localparam logic [DIV_W:0] ONE = (DIV_W+1)'(1);

  state_e           state_q, state_d;
  logic [DIV_W:0]   baud_q, baud_d;        // one bit wider so 1.5/2 stop lengths fit
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       nbits_q, nbits_d;
  logic             par_en_q, par_en_d;
  logic [1:0]       stop_q, stop_d;
  logic             uart_tx_q, uart_tx_d;
  logic             busy_q, busy_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [7:0]     in_mask;
  logic           in_xor;
  logic           in_parity;
  logic [DIV_W:0] period;
  logic [DIV_W:0] stop_len;
  logic [DIV_W:0] limit;
  logic           bit_end;
  logic [2:0]     last_idx;

  // Parity is resolved at accept time over only the bits that will be sent.
  assign in_mask = 8'hFF >> (2'd3 - tx_if.data_bit);
  assign in_xor  = ^(tx_if.tx_data & in_mask);

  // Parity bit value selected by the incoming check_type.
  always_comb begin
    case (tx_if.check_type)
      2'b00:   in_parity = in_xor;
      2'b01:   in_parity = ~in_xor;
      2'b10:   in_parity = 1'b1;
      default: in_parity = 1'b0;
    endcase
  end

  // Divisor values 0 and 1 both mean a one-cycle bit.
  assign period = (div_q > DIV_W'(1)) ? {1'b0, div_q} : ONE;

  // Stop-phase length: P, P + floor(P/2) or 2P cycles.
  always_comb begin
    case (stop_q)
      2'b01:   stop_len = period + (period >> 1);
      2'b10:   stop_len = period << 1;
      default: stop_len = period;
    endcase
  end

  assign limit    = (state_q == STOP) ? stop_len : period;
  assign bit_end  = (baud_q == limit - ONE);
  assign last_idx = {1'b0, nbits_q} + 3'd4;

  // Next-state and datapath logic for the frame sequencer.
  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    div_d     = div_q;
    nbits_d   = nbits_q;
    par_en_d  = par_en_q;
    stop_d    = stop_q;
    uart_tx_d = uart_tx_q;
    busy_d    = busy_q;
    count_d   = count_q;

    // Baud counter restarts at every bit boundary while a frame is active.
    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + ONE;
    end

    case (state_q)
      IDLE: begin
        uart_tx_d = 1'b1;
        if (tx_if.tx_valid) begin
          div_d     = tx_if.clk_div;
          nbits_d   = tx_if.data_bit;
          par_en_d  = tx_if.check_en;
          stop_d    = tx_if.stop_bit;
          shift_d   = tx_if.tx_data;
          parity_d  = in_parity;
          bit_idx_d = '0;
          baud_d    = '0;
          uart_tx_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end
      START: begin
        if (bit_end) begin
          uart_tx_d = shift_q[0];
          shift_d   = shift_q >> 1;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx_q == last_idx) begin
            if (par_en_q) begin
              uart_tx_d = parity_q;
              state_d   = PARITY;
            end else begin
              uart_tx_d = 1'b1;
              state_d   = STOP;
            end
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            uart_tx_d = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          uart_tx_d = 1'b1;
          state_d   = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          busy_d  = 1'b0;
          count_d = count_q + CNT_W'(1);
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset drops the frame and idles the line.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      div_q     <= '0;
      nbits_q   <= '0;
      par_en_q  <= 1'b0;
      stop_q    <= '0;
      uart_tx_q <= 1'b1;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      div_q     <= div_d;
      nbits_q   <= nbits_d;
      par_en_q  <= par_en_d;
      stop_q    <= stop_d;
      uart_tx_q <= uart_tx_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

  assign tx_if.tx_ready      = (state_q == IDLE) && !rst;
  assign tx_if.uart_tx       = uart_tx_q;
  assign tx_if.tx_busy       = busy_q;
  assign tx_if.tx_byte_count = count_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed testbench for uart_tx_engine: frame shapes, parity modes,
// data widths, stop lengths, back-to-back streaming, reset and count wrap.
module tb_uart_tx_engine;

  localparam int DIV_W       = 32;
  localparam int CNT_W       = 16;
  localparam int SMALL_CNT_W = 3;

  typedef struct {
    string       name;
    int          div;
    logic        ce;
    logic [1:0]  ct;
    logic [1:0]  db;
    logic [1:0]  sb;
    logic [7:0]  data;
    logic [15:0] bits;   // start + data (+ parity), first-sent bit in bit 0
    int          nbits;
    int          len;    // expected busy cycles
  } frame_vec_t;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_if #(.DIV_W(DIV_W), .CNT_W(CNT_W))       tx_if ();
  uart_tx_if #(.DIV_W(DIV_W), .CNT_W(SMALL_CNT_W)) small_if ();

  uart_tx_engine #(.DIV_W(DIV_W), .CNT_W(CNT_W)) u_dut (
    .clk   (clk),
    .rst   (rst),
    .tx_if (tx_if)
  );

  uart_tx_engine #(.DIV_W(DIV_W), .CNT_W(SMALL_CNT_W)) u_dut_small (
    .clk   (clk),
    .rst   (rst),
    .tx_if (small_if)
  );

  int   tests_run    = 0;
  int   tests_failed = 0;
  logic line_s [0:2047];
  int   busy_len;
  int   ready_in_busy;

  function automatic logic exp_line(input logic [15:0] bits, input int nbits,
                                    input int p, input int k);
    int slot;
    slot = k / p;
    return (slot < nbits) ? bits[slot[3:0]] : 1'b1;
  endfunction

  // First cycle where the captured line differs from the expected shape, or -1.
  function automatic int line_diff(input logic [15:0] bits, input int nbits,
                                   input int p, input int len);
    for (int k = 0; k < len; k++) begin
      if (line_s[k] !== exp_line(bits, nbits, p, k)) return k;
    end
    return -1;
  endfunction

  task automatic set_cfg(input int div, input logic ce, input logic [1:0] ct,
                         input logic [1:0] db, input logic [1:0] sb);
    tx_if.clk_div    = DIV_W'(div);
    tx_if.check_en   = ce;
    tx_if.check_type = ct;
    tx_if.data_bit   = db;
    tx_if.stop_bit   = sb;
  endtask

  // Offer one byte, then record uart_tx every cycle while tx_busy is high.
  task automatic send_and_capture(input logic [7:0] data);
    int n;
    busy_len      = 0;
    ready_in_busy = 0;
    tx_if.tx_data  = data;
    tx_if.tx_valid = 1'b1;
    n = 0;
    while (tx_if.tx_busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tx_if.tx_valid = 1'b0;
    while (tx_if.tx_busy === 1'b1 && busy_len < 2000) begin
      line_s[busy_len] = tx_if.uart_tx;
      if (tx_if.tx_ready === 1'b1) ready_in_busy++;
      busy_len++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if (tx_if.uart_tx !== 1'b1) begin tests_failed++; $display("FAIL reset_uart_tx got %b expected 1", tx_if.uart_tx); end
    tests_run++;
    if (tx_if.tx_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_ready got %b expected 0", tx_if.tx_ready); end
    tests_run++;
    if (tx_if.tx_busy !== 1'b0) begin tests_failed++; $display("FAIL reset_tx_busy got %b expected 0", tx_if.tx_busy); end
    tests_run++;
    if (tx_if.tx_byte_count !== 16'h0000) begin tests_failed++; $display("FAIL reset_count got %h expected 0000", tx_if.tx_byte_count); end
    rst = 1'b0;
    #1;
    tests_run++;
    if (tx_if.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL release_tx_ready got %b expected 1", tx_if.tx_ready); end
    @(negedge clk);
  endtask

  task automatic test_8n1();
    int d;
    set_cfg(16, 1'b0, 2'b00, 2'b11, 2'b00);
    send_and_capture(8'h55);
    tests_run++;
    if (busy_len !== 160) begin tests_failed++; $display("FAIL 8n1_55_busy_len got %0d expected 160", busy_len); end
    d = line_diff(16'b010101010, 9, 16, busy_len);
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL 8n1_55_line at cycle %0d got %b expected %b", d, line_s[d], exp_line(16'b010101010, 9, 16, d)); end
    tests_run++;
    if (ready_in_busy !== 0) begin tests_failed++; $display("FAIL 8n1_ready_while_busy got %0d cycles expected 0", ready_in_busy); end
    tests_run++;
    if (tx_if.tx_byte_count !== 16'd1) begin tests_failed++; $display("FAIL 8n1_count got %0d expected 1", tx_if.tx_byte_count); end
    tests_run++;
    if (tx_if.uart_tx !== 1'b1 || tx_if.tx_ready !== 1'b1) begin
      tests_failed++; $display("FAIL 8n1_idle_after got line=%b ready=%b expected 1/1", tx_if.uart_tx, tx_if.tx_ready);
    end
  endtask

  task automatic test_parity();
    frame_vec_t vecs [5];
    int d;
    int p;
    vecs = '{
      '{"8E1_AA", 4, 1'b1, 2'b00, 2'b11, 2'b00, 8'hAA, 16'b0101010100, 10, 44},
      '{"8E1_07", 4, 1'b1, 2'b00, 2'b11, 2'b00, 8'h07, 16'b1000001110, 10, 44},
      '{"8O1_55", 4, 1'b1, 2'b01, 2'b11, 2'b00, 8'h55, 16'b1010101010, 10, 44},
      '{"8M1_00", 4, 1'b1, 2'b10, 2'b11, 2'b00, 8'h00, 16'b1000000000, 10, 44},
      '{"8S1_00", 4, 1'b1, 2'b11, 2'b11, 2'b00, 8'h00, 16'b0000000000, 10, 44}
    };
    for (int i = 0; i < 5; i++) begin
      set_cfg(vecs[i].div, vecs[i].ce, vecs[i].ct, vecs[i].db, vecs[i].sb);
      send_and_capture(vecs[i].data);
      p = (vecs[i].div > 1) ? vecs[i].div : 1;
      tests_run++;
      if (busy_len !== vecs[i].len) begin tests_failed++; $display("FAIL %s busy_len got %0d expected %0d", vecs[i].name, busy_len, vecs[i].len); end
      d = line_diff(vecs[i].bits, vecs[i].nbits, p, busy_len);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("FAIL %s line at cycle %0d got %b expected %b", vecs[i].name, d, line_s[d], exp_line(vecs[i].bits, vecs[i].nbits, p, d)); end
    end
  endtask

  task automatic test_data_width();
    frame_vec_t vecs [3];
    int d;
    int p;
    vecs = '{
      '{"7N1_D5", 16, 1'b0, 2'b00, 2'b10, 2'b00, 8'hD5, 16'b10101010,  8, 144},
      '{"7E1_D5",  4, 1'b1, 2'b00, 2'b10, 2'b00, 8'hD5, 16'b010101010, 9, 40},
      '{"5N1_F3",  2, 1'b0, 2'b00, 2'b00, 2'b00, 8'hF3, 16'b100110,    6, 14}
    };
    for (int i = 0; i < 3; i++) begin
      set_cfg(vecs[i].div, vecs[i].ce, vecs[i].ct, vecs[i].db, vecs[i].sb);
      send_and_capture(vecs[i].data);
      p = (vecs[i].div > 1) ? vecs[i].div : 1;
      tests_run++;
      if (busy_len !== vecs[i].len) begin tests_failed++; $display("FAIL %s busy_len got %0d expected %0d", vecs[i].name, busy_len, vecs[i].len); end
      d = line_diff(vecs[i].bits, vecs[i].nbits, p, busy_len);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("FAIL %s line at cycle %0d got %b expected %b", vecs[i].name, d, line_s[d], exp_line(vecs[i].bits, vecs[i].nbits, p, d)); end
    end
  endtask

  task automatic test_stop_and_divisor();
    frame_vec_t vecs [6];
    int d;
    int p;
    vecs = '{
      '{"5N1.5_d16", 16, 1'b0, 2'b00, 2'b00, 2'b01, 8'h13, 16'b100110,    6, 120},
      '{"5N2_d16",   16, 1'b0, 2'b00, 2'b00, 2'b10, 8'h13, 16'b100110,    6, 128},
      '{"5N1.5_d5",   5, 1'b0, 2'b00, 2'b00, 2'b01, 8'h13, 16'b100110,    6, 37},
      '{"5N1_sb11",   4, 1'b0, 2'b00, 2'b00, 2'b11, 8'h13, 16'b100110,    6, 28},
      '{"8N1_d0",     0, 1'b0, 2'b00, 2'b11, 2'b00, 8'hA5, 16'b101001010, 9, 10},
      '{"8N1_d1",     1, 1'b0, 2'b00, 2'b11, 2'b00, 8'hA5, 16'b101001010, 9, 10}
    };
    for (int i = 0; i < 6; i++) begin
      set_cfg(vecs[i].div, vecs[i].ce, vecs[i].ct, vecs[i].db, vecs[i].sb);
      send_and_capture(vecs[i].data);
      p = (vecs[i].div > 1) ? vecs[i].div : 1;
      tests_run++;
      if (busy_len !== vecs[i].len) begin tests_failed++; $display("FAIL %s busy_len got %0d expected %0d", vecs[i].name, busy_len, vecs[i].len); end
      d = line_diff(vecs[i].bits, vecs[i].nbits, p, busy_len);
      tests_run++;
      if (d != -1) begin tests_failed++; $display("FAIL %s line at cycle %0d got %b expected %b", vecs[i].name, d, line_s[d], exp_line(vecs[i].bits, vecs[i].nbits, p, d)); end
    end
  endtask

  task automatic test_back_to_back();
    int   rise [3];
    int   fall [3];
    int   exp_len [3];
    int   nacc;
    int   nfall;
    int   idle_line_bad;
    logic prev_busy;
    logic [CNT_W-1:0] cnt0;
    rise = '{0, 0, 0};
    fall = '{0, 0, 0};
    exp_len = '{160, 160, 144};
    nacc = 0;
    nfall = 0;
    idle_line_bad = 0;
    prev_busy = 1'b0;
    set_cfg(16, 1'b0, 2'b00, 2'b11, 2'b00);
    cnt0 = tx_if.tx_byte_count;
    tx_if.tx_data  = 8'h30;
    tx_if.tx_valid = 1'b1;
    for (int c = 0; c < 700 && nfall < 3; c++) begin
      @(negedge clk);
      if (tx_if.tx_busy === 1'b1 && !prev_busy) begin
        if (nacc < 3) rise[nacc] = c;
        nacc++;
        if (nacc == 1) begin
          tx_if.tx_data = 8'h31;
        end else if (nacc == 2) begin
          tx_if.tx_data  = 8'h32;
          tx_if.data_bit = 2'b10;
        end else begin
          tx_if.tx_valid = 1'b0;
        end
      end
      if (tx_if.tx_busy !== 1'b1 && prev_busy) begin
        if (nfall < 3) fall[nfall] = c;
        nfall++;
      end
      if (tx_if.tx_busy !== 1'b1 && nacc > 0 && tx_if.uart_tx !== 1'b1) idle_line_bad++;
      prev_busy = (tx_if.tx_busy === 1'b1);
    end
    tx_if.tx_valid = 1'b0;
    tests_run++;
    if (nacc != 3 || nfall != 3) begin tests_failed++; $display("FAIL b2b_frames got %0d starts %0d ends expected 3/3", nacc, nfall); end
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (fall[i] - rise[i] != exp_len[i]) begin tests_failed++; $display("FAIL b2b_len%0d got %0d expected %0d", i, fall[i] - rise[i], exp_len[i]); end
    end
    for (int i = 0; i < 2; i++) begin
      tests_run++;
      if (rise[i+1] - fall[i] != 1) begin tests_failed++; $display("FAIL b2b_gap%0d got %0d expected 1", i, rise[i+1] - fall[i]); end
    end
    tests_run++;
    if (idle_line_bad != 0) begin tests_failed++; $display("FAIL b2b_idle_line got %0d low idle cycles expected 0", idle_line_bad); end
    tests_run++;
    if (tx_if.tx_byte_count !== cnt0 + CNT_W'(3)) begin tests_failed++; $display("FAIL b2b_count got %0d expected %0d", tx_if.tx_byte_count, cnt0 + CNT_W'(3)); end
    tx_if.data_bit = 2'b11;
    @(negedge clk);
  endtask

  task automatic test_reset_mid_frame();
    int n;
    int stray;
    int d;
    set_cfg(16, 1'b0, 2'b00, 2'b11, 2'b00);
    tx_if.tx_data  = 8'h55;
    tx_if.tx_valid = 1'b1;
    n = 0;
    while (tx_if.tx_busy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tx_if.tx_valid = 1'b0;
    repeat (70) @(negedge clk);   // inside data bit 3 (cycles 64..79 of the frame)
    tests_run++;
    if (tx_if.uart_tx !== 1'b0 || tx_if.tx_busy !== 1'b1) begin
      tests_failed++; $display("FAIL rstmid_bit3 got line=%b busy=%b expected 0/1", tx_if.uart_tx, tx_if.tx_busy);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (tx_if.uart_tx !== 1'b1 || tx_if.tx_busy !== 1'b0) begin
      tests_failed++; $display("FAIL rstmid_immediate got line=%b busy=%b expected 1/0", tx_if.uart_tx, tx_if.tx_busy);
    end
    tests_run++;
    if (tx_if.tx_byte_count !== 16'd0) begin tests_failed++; $display("FAIL rstmid_count got %0d expected 0", tx_if.tx_byte_count); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests_run++;
    if (tx_if.tx_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_ready got %b expected 1", tx_if.tx_ready); end
    stray = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx_if.tx_busy !== 1'b0 || tx_if.uart_tx !== 1'b1) stray++;
    end
    tests_run++;
    if (stray != 0) begin tests_failed++; $display("FAIL rstmid_no_resend got %0d active cycles expected 0", stray); end
    set_cfg(4, 1'b0, 2'b00, 2'b11, 2'b00);
    send_and_capture(8'h0F);
    tests_run++;
    if (busy_len !== 40) begin tests_failed++; $display("FAIL rstmid_next_len got %0d expected 40", busy_len); end
    d = line_diff(16'b000011110, 9, 4, busy_len);
    tests_run++;
    if (d != -1) begin tests_failed++; $display("FAIL rstmid_next_line at cycle %0d got %b expected %b", d, line_s[d], exp_line(16'b000011110, 9, 4, d)); end
    tests_run++;
    if (tx_if.tx_byte_count !== 16'd1) begin tests_failed++; $display("FAIL rstmid_next_count got %0d expected 1", tx_if.tx_byte_count); end
  endtask

  // Narrow counter instance: 7 frames reach all-ones, the 8th wraps to zero.
  task automatic test_count_wrap();
    int n;
    small_if.clk_div    = '0;
    small_if.check_en   = 1'b0;
    small_if.check_type = 2'b00;
    small_if.data_bit   = 2'b00;
    small_if.stop_bit   = 2'b00;
    for (int f = 0; f < 8; f++) begin
      small_if.tx_data  = 8'(f);
      small_if.tx_valid = 1'b1;
      n = 0;
      while (small_if.tx_busy !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      small_if.tx_valid = 1'b0;
      n = 0;
      while (small_if.tx_busy === 1'b1 && n < 50) begin @(negedge clk); n++; end
      if (f == 6) begin
        tests_run++;
        if (small_if.tx_byte_count !== 3'd7) begin tests_failed++; $display("FAIL wrap_allones got %0d expected 7", small_if.tx_byte_count); end
      end
    end
    tests_run++;
    if (small_if.tx_byte_count !== 3'd0) begin tests_failed++; $display("FAIL wrap_zero got %0d expected 0", small_if.tx_byte_count); end
  endtask

  initial begin
    tx_if.tx_valid    = 1'b0;
    tx_if.tx_data     = 8'h00;
    small_if.tx_valid = 1'b0;
    small_if.tx_data  = 8'h00;
    small_if.clk_div  = '0;
    small_if.check_en = 1'b0;
    small_if.check_type = 2'b00;
    small_if.data_bit = 2'b11;
    small_if.stop_bit = 2'b00;
    set_cfg(16, 1'b0, 2'b00, 2'b11, 2'b00);

    test_reset();
    test_8n1();
    test_parity();
    test_data_width();
    test_stop_and_divisor();
    test_back_to_back();
    test_reset_mid_frame();
    test_count_wrap();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
